serial_sub16: RTL and testbench

SERIAL_SUB16 -- requirements
Module: serial_sub16

---
 rtl/serial_sub16.sv | 136 +++++++++++++
 tb/tb_serial_sub16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub16.sv
// Bit-serial 16-bit subtractor: one full-adder slice computes A + ~B + 1, LSB first,
// over 16 RUN cycles, then presents result/borrow/zero with a one-cycle done pulse.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_sub16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] result,
    output logic        borrow,
    output logic        zero,
    output logic        busy,
    output logic        done
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   work;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           sum_bit;
    logic           cout_bit;
    logic           last_bit_c;
    logic [W-1:0]   final_word_c;

    // Subtraction as A + ~B with the initial carry of 1.
    full_adder u_slice (
        .x    (a_sh[0]),
        .y    (~b_sh[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (cout_bit)
    );

    assign last_bit_c   = (cnt == LAST_BIT);
    assign final_word_c = {sum_bit, work[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; start only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit_c) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        work  <= '0;
                        cnt   <= '0;
                        carry <= 1'b1;
                    end
                end
                RUN: begin
                    work  <= final_word_c;
                    a_sh  <= {1'b0, a_sh[W-1:1]};
                    b_sh  <= {1'b0, b_sh[W-1:1]};
                    carry <= cout_bit;
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result flags only change on the final RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else if (state == RUN && last_bit_c) begin
            result <= final_word_c;
            borrow <= ~cout_bit;
            zero   <= (final_word_c == '0);
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Randomized self-checking bench for serial_sub16 against a plain-arithmetic reference.

module tb_serial_sub16;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] result;
    logic        borrow;
    logic        zero;
    logic        busy;
    logic        done;

    int checks;
    int errors;
    int done_count;
    int cyc;

    logic [15:0] m_res;
    logic        m_borrow;
    logic        m_zero;

    serial_sub16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .result (result),
        .borrow (borrow),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
        int unsigned d;
        d = (32'(a) + 32'h10000 - 32'(b)) % 32'h10000;
        return 16'(d);
    endfunction

    task automatic model_update(input logic [15:0] a, input logic [15:0] b);
        m_res    = ref_diff(a, b);
        m_borrow = (a < b);
        m_zero   = (m_res == 16'h0000);
    endtask

    // One operation; inj_kind 1 pulses a stray start, 2 asserts reset, at busy cycle inj_at+1.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int inj_at, input int inj_kind);
        int edges;
        int busy_cnt;
        int hold_bad;
        int d0;
        d0 = done_count;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        edges = 0;
        busy_cnt = 0;
        hold_bad = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (result !== m_res || borrow !== m_borrow || zero !== m_zero) hold_bad++;
            if (edges == inj_at && inj_kind == 1) begin
                start = 1'b1;
                A = 16'hFFFF;
                B = 16'h0001;
            end else if (edges == inj_at && inj_kind == 2) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_result", 32'(result), 32'h0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_flags", {30'd0, borrow, zero}, 32'd0);
                check("rst_hold_before", 32'(hold_bad), 32'd0);
                m_res = 16'h0000;
                m_borrow = 1'b0;
                m_zero = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                check("rst_no_done", 32'(done_count - d0), 32'd0);
                check("rst_result_after", 32'(result), 32'h0);
                return;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("latency", 32'(edges), 32'd16);
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("hold_in_run", 32'(hold_bad), 32'd0);
        model_update(a, b);
        check("result", 32'(result), 32'(m_res));
        check("borrow", 32'(borrow), 32'(m_borrow));
        check("zero", 32'(zero), 32'(m_zero));
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
        check("done_count", 32'(done_count - d0), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    // Start held high across two operations.
    task automatic back_to_back(input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2);
        int n;
        int k;
        int t[2];
        logic [15:0] got_r[2];
        logic        got_b[2];
        t[0] = 0; t[1] = 0;
        got_r[0] = '0; got_r[1] = '0;
        got_b[0] = 1'b0; got_b[1] = 1'b0;
        A = a1;
        B = b1;
        start = 1'b1;
        @(posedge clk); #1;
        A = a2;
        B = b2;
        n = 0;
        k = 0;
        while (k < 2 && n < 80) begin
            if (done === 1'b1) begin
                got_r[k] = result;
                got_b[k] = borrow;
                t[k] = n;
                k++;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("b2b_pulses", 32'(k), 32'd2);
        check("b2b_first_lat", 32'(t[0]), 32'd16);
        check("b2b_spacing", 32'(t[1] - t[0]), 32'd18);
        check("b2b_res1", 32'(got_r[0]), 32'(ref_diff(a1, b1)));
        check("b2b_bor1", 32'(got_b[0]), 32'(a1 < b1));
        check("b2b_res2", 32'(got_r[1]), 32'(ref_diff(a2, b2)));
        check("b2b_bor2", 32'(got_b[1]), 32'(a2 < b2));
        model_update(a2, b2);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_count = 0;
        cyc = 0;
        m_res = 16'h0000;
        m_borrow = 1'b0;
        m_zero = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        A = 16'h0;
        B = 16'h0;
        #3;
        check("reset_result", 32'(result), 32'h0);
        check("reset_status", {28'd0, borrow, zero, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        op(16'h0005, 16'h0003, -1, 0);
        op(16'h0003, 16'h0005, -1, 0);
        op(16'h1234, 16'h1234, -1, 0);
        op(16'h0000, 16'hFFFF, -1, 0);
        op(16'hABCD, 16'h0123, 4, 1);
        op(16'h4444, 16'h1111, 7, 2);
        op(16'h8000, 16'h0001, -1, 0);
        op(16'h0000, 16'h0000, -1, 0);
        op(16'hFFFF, 16'h0000, -1, 0);
        op(16'h0000, 16'h0001, -1, 0);
        back_to_back(16'h0005, 16'h0003, 16'h0003, 16'h0005);

        for (int i = 0; i < 20; i++) begin
            op(16'($urandom), 16'($urandom), -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
